// File: rtl/wb_stage.sv
// wb_stage: ARMv4 write-back stage (r0-r14 register file, r15 -> PC redirect).
// Optional macro WB_BYPASS_EN: commit value bypassed onto the read ports.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_wb_op,
    input  logic        i_wb_rd_src,
    input  logic        i_wb_rd_vld,
    input  logic [3:0]  i_wb_rd_code,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_rvld,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_ra_code,
    input  logic [3:0]  i_rb_code,
    output logic [31:0] o_ra_data,
    output logic [31:0] o_rb_data,
    output logic        o_stall,
    output logic        o_pc_wr_vld,
    output logic [31:0] o_pc_wr_data
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  lat_rd;
    logic [1:0]  lat_off;
    logic        lat_byte;
    logic [31:0] regs [0:14];

    logic        commit;
    logic        stall;
    logic [3:0]  c_rd;
    logic [1:0]  c_off;
    logic        c_byte;
    logic        c_load;
    logic [31:0] rot;
    logic [31:0] c_val;

    // Pick commit fields from the live bundle (IDLE) or the latched load (WAIT)
    always_comb begin
        commit = 1'b0;
        stall  = 1'b0;
        c_rd   = i_wb_rd_code;
        c_off  = i_wb_op[1:0];
        c_byte = i_wb_op[2];
        c_load = i_wb_rd_src;
        unique case (state)
            IDLE: begin
                commit = i_wb_rd_vld & (~i_wb_rd_src | i_mem_rvld);
                stall  = i_wb_rd_vld & i_wb_rd_src & ~i_mem_rvld;
            end
            WAIT: begin
                commit = i_mem_rvld;
                stall  = ~i_mem_rvld;
                c_rd   = lat_rd;
                c_off  = lat_off;
                c_byte = lat_byte;
                c_load = 1'b1;
            end
        endcase
        if (!rst_n) begin
            commit = 1'b0;
            stall  = 1'b0;
        end
    end

    // Load alignment: rotating right by the byte offset also puts
    // byte lane 'offset' in [7:0], so LDRB just masks the rotated word
    always_comb begin
        rot = i_mem_rdata;
        unique case (c_off)
            2'd0: rot = i_mem_rdata;
            2'd1: rot = {i_mem_rdata[7:0],  i_mem_rdata[31:8]};
            2'd2: rot = {i_mem_rdata[15:0], i_mem_rdata[31:16]};
            2'd3: rot = {i_mem_rdata[23:0], i_mem_rdata[31:24]};
        endcase
        if (!c_load)
            c_val = i_wb_op;
        else if (c_byte)
            c_val = {24'd0, rot[7:0]};
        else
            c_val = rot;
    end

    assign o_stall      = stall;
    assign o_pc_wr_vld  = commit & (c_rd == 4'd15);
    assign o_pc_wr_data = o_pc_wr_vld ? c_val : 32'd0;

    // Read port A: r15 is the fetch PC, others from the file (or bypass)
    always_comb begin
        o_ra_data = 32'd0;
        if (i_ra_code == 4'd15) begin
            o_ra_data = i_pc;
        end else begin
            for (int i = 0; i < 15; i++)
                if (i_ra_code == 4'(i))
                    o_ra_data = regs[i];
`ifdef WB_BYPASS_EN
            if (commit && c_rd == i_ra_code)
                o_ra_data = c_val;
`endif
        end
    end

    // Read port B: same selection as port A
    always_comb begin
        o_rb_data = 32'd0;
        if (i_rb_code == 4'd15) begin
            o_rb_data = i_pc;
        end else begin
            for (int i = 0; i < 15; i++)
                if (i_rb_code == 4'(i))
                    o_rb_data = regs[i];
`ifdef WB_BYPASS_EN
            if (commit && c_rd == i_rb_code)
                o_rb_data = c_val;
`endif
        end
    end

    // Load-wait FSM; latches destination and alignment of a pending load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_rd   <= 4'd0;
            lat_off  <= 2'd0;
            lat_byte <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_wb_rd_vld && i_wb_rd_src && !i_mem_rvld) begin
                        state    <= WAIT;
                        lat_rd   <= i_wb_rd_code;
                        lat_off  <= i_wb_op[1:0];
                        lat_byte <= i_wb_op[2];
                    end
                end
                WAIT: begin
                    if (i_mem_rvld)
                        state <= IDLE;
                end
            endcase
        end
    end

    // Register file r0-r14; r15 commits go to fetch instead
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 15; i++)
                if (commit && c_rd == 4'(i))
                    regs[i] <= c_val;
        end
    end

endmodule
